// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: PSR bit positions, arithmetic flag mask,
// condition-code encodings and the result-buffer state type.
package cr16_pkg;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_T = 1;
  localparam int unsigned PSR_L = 2;
  localparam int unsigned PSR_F = 5;
  localparam int unsigned PSR_Z = 6;
  localparam int unsigned PSR_N = 7;

  // Bits that ALU flag updates may touch; bits 1,3,4 are LPR-only.
  localparam logic [7:0] FLAG_MASK_ARITH = 8'hE5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/psr_cond_unit_if.sv
// Flag-update, SPR and condition request/result signals of the PSR/condition unit.
interface psr_cond_unit_if #(parameter int unsigned WIDTH = 16);

  logic [7:0]       alu_psr;
  logic             flag_we;
  logic [7:0]       flag_mask;
  logic             psr_wr_en;
  logic [WIDTH-1:0] psr_wr_data;
  logic [7:0]       psr;
  logic [WIDTH-1:0] psr_rd_data;
  logic             carry_out;
  logic             cond_valid;
  logic [3:0]       cond_code;
  logic             cond_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [WIDTH-1:0] scond_data;

  modport master (
    output alu_psr, flag_we, flag_mask, psr_wr_en, psr_wr_data,
    output cond_valid, cond_code, res_ready,
    input  psr, psr_rd_data, carry_out, cond_ready, res_valid, res_taken, scond_data
  );

  modport slave (
    input  alu_psr, flag_we, flag_mask, psr_wr_en, psr_wr_data,
    input  cond_valid, cond_code, res_ready,
    output psr, psr_rd_data, carry_out, cond_ready, res_valid, res_taken, scond_data
  );

endinterface

// File: rtl/psr_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against a PSR value.
module psr_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [7:0] psr,
  output logic       taken
);

  logic c, l, f, z, n;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  // Condition table lookup.
  always_comb begin
    taken = 1'b0;
    case (cond_code)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// PSR register with LPR/flag update, condition evaluation on the
// post-update PSR, and a one-entry registered result buffer.
module psr_cond_unit
  import cr16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  psr_cond_unit_if.slave bus
);

  logic [7:0] psr_q;
  logic [7:0] psr_next;
  logic [7:0] upd_mask;
  logic       eval_taken;
  logic       accept;
  logic       taken_q;
  logic       unused_wr_hi;

  buf_state_e state, state_next;

  assign upd_mask     = bus.flag_mask & FLAG_MASK_ARITH;
  assign unused_wr_hi = ^bus.psr_wr_data[WIDTH-1:8];

  // PSR next value: LPR wins over masked ALU flag update.
  always_comb begin
    psr_next = psr_q;
    if (bus.psr_wr_en) begin
      psr_next = bus.psr_wr_data[7:0];
    end else if (bus.flag_we) begin
      psr_next = (psr_q & ~upd_mask) | (bus.alu_psr & upd_mask);
    end
  end

  // PSR register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) psr_q <= '0;
    else       psr_q <= psr_next;
  end

  // Requests are evaluated on psr_next so same-cycle updates are visible.
  psr_cond_eval u_eval (
    .cond_code (bus.cond_code),
    .psr       (psr_next),
    .taken     (eval_taken)
  );

  // Buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_next;
  end

  // Buffer next state: accept fills (or refills while draining), drain empties.
  always_comb begin
    state_next = state;
    case (state)
      BUF_EMPTY: if (accept) state_next = BUF_FULL;
      BUF_FULL:  if (!accept && bus.res_ready) state_next = BUF_EMPTY;
      default:   state_next = BUF_EMPTY;
    endcase
  end

  // Buffer outputs: ready whenever the slot is empty or being drained.
  always_comb begin
    bus.res_valid  = (state == BUF_FULL);
    bus.cond_ready = (state == BUF_EMPTY) || bus.res_ready;
    accept         = bus.cond_valid && bus.cond_ready;
  end

  // Decision register; only loaded on accept, so idle cond_code never reaches state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       taken_q <= 1'b0;
    else if (accept) taken_q <= eval_taken;
  end

  assign bus.psr         = psr_q;
  assign bus.psr_rd_data = {{(WIDTH-8){1'b0}}, psr_q};
  assign bus.carry_out   = psr_q[PSR_C];
  assign bus.res_taken   = taken_q;
  assign bus.scond_data  = {{(WIDTH-1){1'b0}}, taken_q};

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: the driver queues expected decisions,
// a negedge monitor pops and compares on every res_valid & res_ready.
module tb_psr_cond_unit;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  logic sb[$];

  psr_cond_unit_if #(.WIDTH(WIDTH)) bus ();

  psr_cond_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference condition table written from the {C,L,F,Z,N} definitions.
  function automatic logic model_taken(logic [3:0] code, logic c, logic l, logic f,
                                       logic z, logic n);
    case (code)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return c;
      4'd3:  return ~c;
      4'd4:  return l;
      4'd5:  return ~l;
      4'd6:  return n;
      4'd7:  return ~n;
      4'd8:  return f;
      4'd9:  return ~f;
      4'd10: return ~l & ~z;
      4'd11: return l | z;
      4'd12: return ~n & ~z;
      4'd13: return n | z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: compares each consumed decision with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 16'd1, 16'd0);
      end else begin
        logic e;
        e = sb.pop_front();
        check("res_taken", {15'd0, bus.res_taken}, {15'd0, e});
        check("scond_data", bus.scond_data, {15'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits (bounded) for acceptance, queues the expectation.
  task automatic issue(input logic [3:0] code, input logic exp, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    bus.cond_valid = 1'b1;
    bus.cond_code  = code;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cond_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) check("accept_timeout", 16'd0, 16'd1);
    else     sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.cond_valid = 1'b0;
    bus.cond_code  = 4'hx;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] p;

    reset           = 1'b1;
    bus.alu_psr     = '0;
    bus.flag_we     = 1'b0;
    bus.flag_mask   = '0;
    bus.psr_wr_en   = 1'b0;
    bus.psr_wr_data = '0;
    bus.cond_valid  = 1'b0;
    bus.cond_code   = 4'h0;
    bus.res_ready   = 1'b1;

    // Reset state.
    #12;
    check("rst_psr", {8'd0, bus.psr}, 16'h0000);
    check("rst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    check("rst_res_taken", {15'd0, bus.res_taken}, 16'd0);
    check("rst_cond_ready", {15'd0, bus.cond_ready}, 16'd1);
    check("rst_psr_rd_data", bus.psr_rd_data, 16'h0000);
    check("rst_carry_out", {15'd0, bus.carry_out}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Flag update bypass: EQ sees Z set in the same cycle.
    bus.flag_we   = 1'b1;
    bus.flag_mask = 8'hE5;
    bus.alu_psr   = 8'h40;
    issue(4'h0, 1'b1, w);
    bus.flag_we = 1'b0;
    check("bypass_flag_psr", {8'd0, bus.psr}, 16'h0040);
    check("bypass_res_valid", {15'd0, bus.res_valid}, 16'd1);

    // LPR bypass then back-to-back LO, HS, HI, LS with L=1.
    bus.psr_wr_en   = 1'b1;
    bus.psr_wr_data = 16'h0004;
    issue(4'hA, 1'b0, w);
    bus.psr_wr_en = 1'b0;
    check("b2b_wait0", w[15:0], 16'd0);
    issue(4'hB, 1'b1, w);
    check("b2b_wait1", w[15:0], 16'd0);
    issue(4'h4, 1'b1, w);
    check("b2b_wait2", w[15:0], 16'd0);
    issue(4'h5, 1'b0, w);
    check("b2b_wait3", w[15:0], 16'd0);
    check("b2b_psr", {8'd0, bus.psr}, 16'h0004);
    step();
    check("b2b_drained", {15'd0, bus.res_valid}, 16'd0);
    check("b2b_taken_hold", {15'd0, bus.res_taken}, 16'd0);

    // LPR overrides a same-cycle flag update.
    bus.psr_wr_en   = 1'b1;
    bus.psr_wr_data = 16'h00FF;
    bus.flag_we     = 1'b1;
    bus.flag_mask   = 8'hFF;
    bus.alu_psr     = 8'h00;
    step();
    bus.psr_wr_en = 1'b0;
    bus.flag_we   = 1'b0;
    check("lpr_psr", {8'd0, bus.psr}, 16'h00FF);
    check("lpr_rd_data", bus.psr_rd_data, 16'h00FF);
    check("lpr_carry", {15'd0, bus.carry_out}, 16'd1);

    // Flag update with full mask leaves bits 1,3,4 alone.
    bus.flag_we   = 1'b1;
    bus.flag_mask = 8'hFF;
    bus.alu_psr   = 8'h00;
    step();
    bus.flag_we = 1'b0;
    check("flag_t_bits_hold", {8'd0, bus.psr}, 16'h001A);
    check("flag_carry_clr", {15'd0, bus.carry_out}, 16'd0);

    // Partial mask: only C and N enabled.
    bus.flag_we   = 1'b1;
    bus.flag_mask = 8'h81;
    bus.alu_psr   = 8'hFF;
    step();
    bus.flag_we = 1'b0;
    check("flag_partial_mask", {8'd0, bus.psr}, 16'h009B);

    // Stall: GT with N=1 held while res_ready=0.
    bus.res_ready = 1'b0;
    issue(4'h6, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_res_valid", {15'd0, bus.res_valid}, 16'd1);
      check("stall_res_taken", {15'd0, bus.res_taken}, 16'd1);
      check("stall_cond_ready", {15'd0, bus.cond_ready}, 16'd0);
    end
    #1;
    bus.res_ready = 1'b1;
    step();
    check("stall_drained", {15'd0, bus.res_valid}, 16'd0);
    check("stall_taken_hold", {15'd0, bus.res_taken}, 16'd1);

    // Async reset while a result is pending.
    bus.res_ready = 1'b0;
    issue(4'hE, 1'b1, w);
    #2;
    check("pre_rst_valid", {15'd0, bus.res_valid}, 16'd1);
    reset = 1'b1;
    #1;
    check("async_rst_psr", {8'd0, bus.psr}, 16'h0000);
    check("async_rst_valid", {15'd0, bus.res_valid}, 16'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_cond_ready", {15'd0, bus.cond_ready}, 16'd1);
    check("post_rst_valid", {15'd0, bus.res_valid}, 16'd0);
    step();

    // Sweep every code over every {C,L,F,Z,N}, PSR loaded in the accept cycle.
    for (int f = 0; f < 32; f++) begin
      p = '0;
      p[0] = f[0];
      p[2] = f[1];
      p[5] = f[2];
      p[6] = f[3];
      p[7] = f[4];
      p[1] = f[0] ^ f[2];
      p[4] = f[1];
      for (int c = 0; c < 16; c++) begin
        if (c == 0) begin
          bus.psr_wr_en   = 1'b1;
          bus.psr_wr_data = {8'hA5, p};
        end
        issue(c[3:0], model_taken(c[3:0], f[0], f[1], f[2], f[3], f[4]), w);
        bus.psr_wr_en = 1'b0;
      end
      check("sweep_psr", bus.psr_rd_data, {8'd0, p});
    end

    step();
    step();
    check("scoreboard_empty", sb.size() > 0 ? 16'd1 : 16'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
